pipeline_hazard_controller: RTL and testbench

// Central stall/flush sequencer for the 5-stage CPU pipeline; companion to the stage-3 forwarding unit.

---
 rtl/pipeline_hazard_controller.sv | 132 +++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves load-use, multi-cycle MUL/DIV,
// busy data memory and taken-branch hazards, and counts cycles in which the PC is held.
module pipeline_hazard_controller #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [4:0]           ID_ADDR1,
  input  logic [4:0]           ID_ADDR2,
  input  logic                 ID_USES_RS1,
  input  logic                 ID_USES_RS2,
  input  logic [4:0]           EX_ADDR,
  input  logic                 EX_REGWRITE_EN,
  input  logic                 EX_MEM_READ,
  input  logic                 EX_MULDIV,
  input  logic                 BRANCH_TAKEN,
  input  logic                 MEM_BUSY,
  output logic                 PC_STALL,
  output logic                 IF_ID_STALL,
  output logic                 ID_EX_STALL,
  output logic                 EX_MEM_STALL,
  output logic                 IF_ID_FLUSH,
  output logic                 ID_EX_BUBBLE,
  output logic                 EX_MEM_BUBBLE,
  output logic                 MEM_WB_BUBBLE,
  output logic                 MULDIV_START,
  output logic [1:0]           STATE,
  output logic [CNT_WIDTH-1:0] STALL_COUNT
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MULDIV  = 2'b01,
    MEMWAIT = 2'b10,
    UNUSED  = 2'b11
  } state_t;

  state_t               state, state_next;
  logic [3:0]           cnt, cnt_next;
  logic [CNT_WIDTH-1:0] stall_count;
  logic                 load_use;

  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble, muldiv_start;

  assign load_use = EX_MEM_READ & EX_REGWRITE_EN & (EX_ADDR != 5'd0) &
                    ((ID_USES_RS1 & (EX_ADDR == ID_ADDR1)) |
                     (ID_USES_RS2 & (EX_ADDR == ID_ADDR2)));

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    ex_mem_stall  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    muldiv_start  = 1'b0;
    case (state)
      // MEMWAIT with the memory released behaves exactly like RUN, so both share one decode.
      RUN, MEMWAIT: begin
        state_next = RUN;
        if (MEM_BUSY) begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_stall  = 1'b1;
          mem_wb_bubble = 1'b1;
          state_next    = MEMWAIT;
        end else if (EX_MULDIV) begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_bubble = 1'b1;
          muldiv_start  = 1'b1;
          cnt_next      = 4'(MULDIV_CYCLES - 1);
          state_next    = MULDIV;
        end else if (BRANCH_TAKEN) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
        end
      end
      MULDIV: begin
        if (cnt != 4'd0) begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_bubble = 1'b1;
          cnt_next      = cnt - 4'd1;
        end else begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= RUN;
      cnt         <= 4'd0;
      stall_count <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (pc_stall && (stall_count != {CNT_WIDTH{1'b1}}))
        stall_count <= stall_count + 1'b1;
    end
  end

  // Controls are forced low while reset is held, independent of the clock.
  assign PC_STALL      = RESET & pc_stall;
  assign IF_ID_STALL   = RESET & if_id_stall;
  assign ID_EX_STALL   = RESET & id_ex_stall;
  assign EX_MEM_STALL  = RESET & ex_mem_stall;
  assign IF_ID_FLUSH   = RESET & if_id_flush;
  assign ID_EX_BUBBLE  = RESET & id_ex_bubble;
  assign EX_MEM_BUBBLE = RESET & ex_mem_bubble;
  assign MEM_WB_BUBBLE = RESET & mem_wb_bubble;
  assign MULDIV_START  = RESET & muldiv_start;
  assign STATE         = state;
  assign STALL_COUNT   = stall_count;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: hand-computed control vectors, states and
// stall counts, plus a 4-bit-counter instance for saturation.
module tb_pipeline_hazard_controller;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_addr1, id_addr2, ex_addr;
  logic       id_uses_rs1, id_uses_rs2, ex_regwrite_en, ex_mem_read;
  logic       ex_muldiv, branch_taken, mem_busy;

  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic        if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble, muldiv_start;
  logic [1:0]  state;
  logic [15:0] stall_count;

  logic        s_pc_stall, s_if_id_stall, s_id_ex_stall, s_ex_mem_stall;
  logic        s_if_id_flush, s_id_ex_bubble, s_ex_mem_bubble, s_mem_wb_bubble, s_muldiv_start;
  logic [1:0]  s_state;
  logic [3:0]  s_stall_count;

  logic [8:0]  ctrl;
  int          checks = 0;
  int          errors = 0;
  int          exp_count = 0;

  // Bit order: PC, IF_ID, ID_EX, EX_MEM stalls; flush; ID_EX, EX_MEM, MEM_WB bubbles; start
  localparam logic [8:0] C_NONE  = 9'b000000000;
  localparam logic [8:0] C_LU    = 9'b110001000;
  localparam logic [8:0] C_BUSY  = 9'b111100010;
  localparam logic [8:0] C_MDST  = 9'b111000101;
  localparam logic [8:0] C_MD    = 9'b111000100;
  localparam logic [8:0] C_BR    = 9'b000011000;

  assign ctrl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
                 id_ex_bubble, ex_mem_bubble, mem_wb_bubble, muldiv_start};

  pipeline_hazard_controller #(.MULDIV_CYCLES(4), .CNT_WIDTH(16)) dut (
    .CLK(clk), .RESET(rst_n),
    .ID_ADDR1(id_addr1), .ID_ADDR2(id_addr2),
    .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2),
    .EX_ADDR(ex_addr), .EX_REGWRITE_EN(ex_regwrite_en), .EX_MEM_READ(ex_mem_read),
    .EX_MULDIV(ex_muldiv), .BRANCH_TAKEN(branch_taken), .MEM_BUSY(mem_busy),
    .PC_STALL(pc_stall), .IF_ID_STALL(if_id_stall), .ID_EX_STALL(id_ex_stall),
    .EX_MEM_STALL(ex_mem_stall), .IF_ID_FLUSH(if_id_flush), .ID_EX_BUBBLE(id_ex_bubble),
    .EX_MEM_BUBBLE(ex_mem_bubble), .MEM_WB_BUBBLE(mem_wb_bubble),
    .MULDIV_START(muldiv_start), .STATE(state), .STALL_COUNT(stall_count)
  );

  pipeline_hazard_controller #(.MULDIV_CYCLES(4), .CNT_WIDTH(4)) dut_sat (
    .CLK(clk), .RESET(rst_n),
    .ID_ADDR1(id_addr1), .ID_ADDR2(id_addr2),
    .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2),
    .EX_ADDR(ex_addr), .EX_REGWRITE_EN(ex_regwrite_en), .EX_MEM_READ(ex_mem_read),
    .EX_MULDIV(ex_muldiv), .BRANCH_TAKEN(branch_taken), .MEM_BUSY(mem_busy),
    .PC_STALL(s_pc_stall), .IF_ID_STALL(s_if_id_stall), .ID_EX_STALL(s_id_ex_stall),
    .EX_MEM_STALL(s_ex_mem_stall), .IF_ID_FLUSH(s_if_id_flush), .ID_EX_BUBBLE(s_id_ex_bubble),
    .EX_MEM_BUBBLE(s_ex_mem_bubble), .MEM_WB_BUBBLE(s_mem_wb_bubble),
    .MULDIV_START(s_muldiv_start), .STATE(s_state), .STALL_COUNT(s_stall_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_addr1 = 5'd0; id_addr2 = 5'd0; ex_addr = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_regwrite_en = 1'b0; ex_mem_read = 1'b0;
    ex_muldiv = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 32'(ctrl), 32'(C_NONE));
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_count", 32'(stall_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Load-use on rs2
    ex_mem_read = 1'b1; ex_regwrite_en = 1'b1; ex_addr = 5'd5;
    id_addr2 = 5'd5; id_uses_rs2 = 1'b1;
    #1 chk("lu_rs2_ctrl", 32'(ctrl), 32'(C_LU));
    tick(); exp_count++;
    chk("lu_rs2_count", 32'(stall_count), 32'(exp_count));

    // Same pattern targeting x0: no hazard
    ex_addr = 5'd0; id_addr2 = 5'd0;
    #1 chk("lu_x0_ctrl", 32'(ctrl), 32'(C_NONE));
    tick();
    chk("lu_x0_count", 32'(stall_count), 32'(exp_count));

    // Load-use on rs1, then rs1 not used
    ex_addr = 5'd7; id_addr1 = 5'd7; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b0;
    #1 chk("lu_rs1_ctrl", 32'(ctrl), 32'(C_LU));
    id_uses_rs1 = 1'b0;
    #1 chk("lu_rs1_unused", 32'(ctrl), 32'(C_NONE));
    id_uses_rs1 = 1'b1; ex_regwrite_en = 1'b0;
    #1 chk("lu_no_regwrite", 32'(ctrl), 32'(C_NONE));
    ex_regwrite_en = 1'b1;

    // Branch overrides load-use
    branch_taken = 1'b1;
    #1 chk("br_over_lu", 32'(ctrl), 32'(C_BR));
    tick();
    chk("br_count", 32'(stall_count), 32'(exp_count));
    chk("br_state", 32'(state), 32'd0);
    clear_inputs();

    // MUL/DIV: 4 stall cycles, single start pulse; later busy/branch ignored
    ex_muldiv = 1'b1;
    #1 chk("md0_ctrl", 32'(ctrl), 32'(C_MDST));
    chk("md0_state", 32'(state), 32'd0);
    tick(); exp_count++;
    chk("md1_ctrl", 32'(ctrl), 32'(C_MD));
    chk("md1_state", 32'(state), 32'd1);
    mem_busy = 1'b1; branch_taken = 1'b1;
    #1 chk("md1_ignore", 32'(ctrl), 32'(C_MD));
    tick(); exp_count++;
    chk("md2_ctrl", 32'(ctrl), 32'(C_MD));
    mem_busy = 1'b0; branch_taken = 1'b0;
    tick(); exp_count++;
    chk("md3_ctrl", 32'(ctrl), 32'(C_MD));
    chk("md3_state", 32'(state), 32'd1);
    tick(); exp_count++;
    chk("md4_ctrl", 32'(ctrl), 32'(C_NONE));
    chk("md4_state", 32'(state), 32'd1);
    ex_muldiv = 1'b0;
    tick();
    chk("md5_state", 32'(state), 32'd0);
    chk("md5_ctrl", 32'(ctrl), 32'(C_NONE));
    chk("md_count", 32'(stall_count), 32'(exp_count));

    // MEM_BUSY for 3 cycles with a pending branch, serviced on release
    mem_busy = 1'b1; branch_taken = 1'b1;
    #1 chk("mb0_ctrl", 32'(ctrl), 32'(C_BUSY));
    chk("mb0_state", 32'(state), 32'd0);
    tick(); exp_count++;
    chk("mb1_ctrl", 32'(ctrl), 32'(C_BUSY));
    chk("mb1_state", 32'(state), 32'd2);
    tick(); exp_count++;
    chk("mb2_ctrl", 32'(ctrl), 32'(C_BUSY));
    tick(); exp_count++;
    mem_busy = 1'b0;
    #1 chk("mb_rel_ctrl", 32'(ctrl), 32'(C_BR));
    chk("mb_rel_state", 32'(state), 32'd2);
    tick();
    chk("mb_after_state", 32'(state), 32'd0);
    chk("mb_count", 32'(stall_count), 32'(exp_count));
    clear_inputs();

    // MEMWAIT released straight into a MUL/DIV
    mem_busy = 1'b1;
    tick();
    mem_busy = 1'b0; ex_muldiv = 1'b1;
    #1 chk("mw_md_ctrl", 32'(ctrl), 32'(C_MDST));
    tick();
    chk("mw_md_state", 32'(state), 32'd1);

    // Reset mid-MULDIV at cnt=2 (one more edge after entering with cnt=3)
    tick();
    chk("rst_pre_ctrl", 32'(ctrl), 32'(C_MD));
    rst_n = 1'b0;
    #1 chk("rst_async_ctrl", 32'(ctrl), 32'(C_NONE));
    chk("rst_async_state", 32'(state), 32'd0);
    chk("rst_async_count", 32'(stall_count), 32'd0);
    ex_muldiv = 1'b0;
    tick();
    rst_n = 1'b1;
    #1 chk("rst_rel_ctrl", 32'(ctrl), 32'(C_NONE));
    tick();
    chk("rst_rel_ctrl2", 32'(ctrl), 32'(C_NONE));
    chk("rst_rel_state", 32'(state), 32'd0);
    chk("rst_rel_count", 32'(stall_count), 32'd0);

    // 20 busy cycles: 4-bit counter saturates at 15, 16-bit counter reaches 20
    mem_busy = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) chk("sat_14", 32'(s_stall_count), 32'd14);
    end
    chk("sat_15", 32'(s_stall_count), 32'd15);
    chk("wide_20", 32'(stall_count), 32'd20);
    chk("sat_state", 32'(s_state), 32'd2);
    mem_busy = 1'b0;
    tick();
    chk("sat_hold", 32'(s_stall_count), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
